// File: rtl/dual_grey_ram_arb_pkg.sv
// dual_grey_ram_arb_pkg
// Shared constants and types for the dual-camera grey-pixel RAM arbiter.
// Frame geometry, address widths, the bank bit position, the grant-state
// encoding and the packed FIFO entry layout live here, so the interface,
// the FIFO and the arbiter all agree on them.
package dual_grey_ram_arb_pkg;

  localparam int FRAME_W      = 160;
  localparam int FRAME_H      = 120;
  localparam int FRAME_PIXELS = FRAME_W * FRAME_H;
  localparam int PIX_ADDR_W   = 15;
  localparam int RAM_ADDR_W   = 16;
  localparam int BANK_BIT     = 15;
  localparam int GREY_W       = 8;

  // Grant state = the RAM access being issued in the current cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_RD = 2'd1,
    GNT_L  = 2'd2,
    GNT_R  = 2'd3
  } gnt_state_t;

  // One queued pixel write: the address sits in the upper bits.
  typedef struct packed {
    logic [PIX_ADDR_W-1:0] addr;
    logic [GREY_W-1:0]     grey;
  } pix_entry_t;

  localparam int ENTRY_W = $bits(pix_entry_t);

  // Builds a RAM address from a bank select (0 left, 1 right) and a pixel address.
  function automatic logic [RAM_ADDR_W-1:0] bank_addr(input logic bank,
                                                      input logic [PIX_ADDR_W-1:0] addr);
    logic [RAM_ADDR_W-1:0] a;
    a = '0;
    a[PIX_ADDR_W-1:0] = addr;
    a[BANK_BIT] = bank;
    return a;
  endfunction

endpackage

// File: rtl/dual_grey_ram_arb_if.sv
// dual_grey_ram_arb_if
// Bundles the pixel strobes, the stereo-matcher read port and the RAM side
// of the arbiter.
//   master : the environment (drives strobes, read requests, flush, clr_ovf)
//   slave  : the arbiter (drives RAM enables/address/data, rd_ack, flags, busy)
// Clock and reset are not part of the bundle.
interface dual_grey_ram_arb_if;
  import dual_grey_ram_arb_pkg::*;

  logic                  l_vld;
  logic [PIX_ADDR_W-1:0] l_addr;
  logic [GREY_W-1:0]     l_grey;
  logic                  r_vld;
  logic [PIX_ADDR_W-1:0] r_addr;
  logic [GREY_W-1:0]     r_grey;
  logic                  rd_req;
  logic [RAM_ADDR_W-1:0] rd_addr;
  logic                  flush;
  logic                  clr_ovf;

  logic                  ram_we;
  logic                  ram_re;
  logic [RAM_ADDR_W-1:0] ram_addr;
  logic [GREY_W-1:0]     ram_wdata;
  logic                  rd_ack;
  logic                  l_ovf;
  logic                  r_ovf;
  logic                  busy;

  modport master (
    output l_vld, l_addr, l_grey, r_vld, r_addr, r_grey,
           rd_req, rd_addr, flush, clr_ovf,
    input  ram_we, ram_re, ram_addr, ram_wdata, rd_ack, l_ovf, r_ovf, busy
  );

  modport slave (
    input  l_vld, l_addr, l_grey, r_vld, r_addr, r_grey,
           rd_req, rd_addr, flush, clr_ovf,
    output ram_we, ram_re, ram_addr, ram_wdata, rd_ack, l_ovf, r_ovf, busy
  );

endinterface

// File: rtl/dual_grey_ram_arb_grey_wr_fifo.sv
// grey_wr_fifo
// Small synchronous FIFO holding pending pixel writes for one camera side.
// Ports:
//   pclk, rst : clock, asynchronous active-high reset
//   flush     : empties the FIFO on the edge; a push in the same cycle is lost
//   push      : enqueue wdata (accepted when not full, or when full and popping)
//   pop       : dequeue the head entry
//   wdata     : entry to enqueue
//   rdata     : current head entry (valid when not empty)
//   full      : count == DEPTH
//   empty     : count == 0
//   count     : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the read/write pointers wrap naturally.
module grey_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 23,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // A push into a full FIFO is still accepted when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rdata = mem[rd_ptr];

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge pclk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/dual_grey_ram_arb.sv
// dual_grey_ram_arb
// Merges two decimated camera pixel streams and a stereo-matcher read port
// onto one single-port frame RAM (bank 0 = left, bank 1 = right).
// Ports:
//   pclk : sole clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave side of dual_grey_ram_arb_if
//          in  : l_/r_ vld/addr/grey strobes, rd_req/rd_addr, flush, clr_ovf
//          out : ram_we/ram_re/ram_addr/ram_wdata, rd_ack, l_ovf/r_ovf, busy
// Each side's strobes queue in a grey_wr_fifo. One RAM access is granted per
// cycle from the current FIFO/request state and registered onto the RAM pins:
//   1. a write side at or above ALMOST_FULL (both -> round-robin pointer)
//   2. the read request
//   3. any non-empty write side (both -> round-robin pointer)
module dual_grey_ram_arb
  import dual_grey_ram_arb_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int ALMOST_FULL = 3
) (
  input  logic                pclk,
  input  logic                rst,
  dual_grey_ram_arb_if.slave  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] AF_CNT = CNT_W'(ALMOST_FULL);

  logic             l_full, l_empty, r_full, r_empty;
  logic [CNT_W-1:0] l_count, r_count;
  pix_entry_t       l_head, r_head;
  logic             l_pop, r_pop;
  logic             l_drop, r_drop;
  logic             rd_pend;
  logic             l_ok, r_ok, l_hot, r_hot;

  gnt_state_t       state;
  gnt_state_t       nxt;
  // 0 = left is preferred on the next tie, 1 = right.
  logic             rr_ptr;

  logic                  ram_we_q;
  logic                  ram_re_q;
  logic                  rd_ack_q;
  logic [RAM_ADDR_W-1:0] ram_addr_q;
  logic [GREY_W-1:0]     ram_wdata_q;
  logic                  l_ovf_q;
  logic                  r_ovf_q;

  grey_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_l_fifo (
    .pclk  (pclk),
    .rst   (rst),
    .flush (bus.flush),
    .push  (bus.l_vld),
    .pop   (l_pop),
    .wdata ({bus.l_addr, bus.l_grey}),
    .rdata (l_head),
    .full  (l_full),
    .empty (l_empty),
    .count (l_count)
  );

  grey_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_r_fifo (
    .pclk  (pclk),
    .rst   (rst),
    .flush (bus.flush),
    .push  (bus.r_vld),
    .pop   (r_pop),
    .wdata ({bus.r_addr, bus.r_grey}),
    .rdata (r_head),
    .full  (r_full),
    .empty (r_empty),
    .count (r_count)
  );

  // While rd_ack is out the requester has not yet had a chance to drop rd_req,
  // so the request is masked for that cycle; if it is still high afterwards it
  // is a fresh request.
  assign rd_pend = bus.rd_req && (state != GNT_RD);

  // Flush discards the queued entries, so nothing is granted from them that cycle.
  assign l_ok  = !l_empty && !bus.flush;
  assign r_ok  = !r_empty && !bus.flush;
  assign l_hot = l_ok && (l_count >= AF_CNT);
  assign r_hot = r_ok && (r_count >= AF_CNT);

  always_comb begin
    nxt = IDLE;
    if (l_hot && r_hot) begin
      nxt = rr_ptr ? GNT_R : GNT_L;
    end else if (l_hot) begin
      nxt = GNT_L;
    end else if (r_hot) begin
      nxt = GNT_R;
    end else if (rd_pend) begin
      nxt = GNT_RD;
    end else if (l_ok && r_ok) begin
      nxt = rr_ptr ? GNT_R : GNT_L;
    end else if (l_ok) begin
      nxt = GNT_L;
    end else if (r_ok) begin
      nxt = GNT_R;
    end
  end

  assign l_pop = (nxt == GNT_L);
  assign r_pop = (nxt == GNT_R);

  // A strobe is lost only when its FIFO is full and nothing leaves it this edge.
  assign l_drop = bus.l_vld && l_full && !l_pop && !bus.flush;
  assign r_drop = bus.r_vld && r_full && !r_pop && !bus.flush;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      l_ovf_q     <= 1'b0;
      r_ovf_q     <= 1'b0;
    end else begin
      state    <= nxt;
      ram_we_q <= (nxt == GNT_L) || (nxt == GNT_R);
      ram_re_q <= (nxt == GNT_RD);
      rd_ack_q <= (nxt == GNT_RD);
      // Address/data only move on a grant; otherwise they hold.
      case (nxt)
        GNT_L: begin
          ram_addr_q  <= bank_addr(1'b0, l_head.addr);
          ram_wdata_q <= l_head.grey;
          rr_ptr      <= 1'b1;
        end
        GNT_R: begin
          ram_addr_q  <= bank_addr(1'b1, r_head.addr);
          ram_wdata_q <= r_head.grey;
          rr_ptr      <= 1'b0;
        end
        GNT_RD: begin
          ram_addr_q <= bus.rd_addr;
        end
        default: begin
        end
      endcase
      // A new overflow beats a simultaneous clear.
      if (l_drop) begin
        l_ovf_q <= 1'b1;
      end else if (bus.clr_ovf) begin
        l_ovf_q <= 1'b0;
      end
      if (r_drop) begin
        r_ovf_q <= 1'b1;
      end else if (bus.clr_ovf) begin
        r_ovf_q <= 1'b0;
      end
    end
  end

  assign bus.ram_we    = ram_we_q;
  assign bus.ram_re    = ram_re_q;
  assign bus.rd_ack    = rd_ack_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.l_ovf     = l_ovf_q;
  assign bus.r_ovf     = r_ovf_q;
  // Gated by rst so every output reads 0 while reset is held.
  assign bus.busy      = !rst && (!l_empty || !r_empty || bus.rd_req);

endmodule

// File: tb/tb_dual_grey_ram_arb.sv
// tb_dual_grey_ram_arb
// Self-checking bench for dual_grey_ram_arb. A queue-based model predicts
// every RAM access, flag and busy level; a compare process checks the DUT
// against it each cycle, and directed scenarios pin the model with literals.
module tb_dual_grey_ram_arb;
  import dual_grey_ram_arb_pkg::*;

  localparam int DEPTH = 4;
  localparam int AF    = 3;

  logic pclk = 1'b0;
  logic rst  = 1'b1;

  always #5 pclk = ~pclk;

  dual_grey_ram_arb_if bus();

  dual_grey_ram_arb #(
    .FIFO_DEPTH  (DEPTH),
    .ALMOST_FULL (AF)
  ) dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model state: pending writes per side as {addr, grey}.
  logic [22:0] lq[$];
  logic [22:0] rq[$];
  bit          m_prefer_right;
  bit          m_last_was_read;
  logic        exp_we, exp_re, exp_ack, exp_lovf, exp_rovf;
  logic [15:0] exp_addr;
  logic [7:0]  exp_wdata;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs seen at that edge.
  task automatic modelStep();
    bit rd_wanted, l_can, r_can, l_urgent, r_urgent;
    int choice;
    logic [22:0] item;
    bit l_lost, r_lost;
    if (rst) begin
      lq.delete();
      rq.delete();
      m_prefer_right  = 0;
      m_last_was_read = 0;
      exp_we = 0; exp_re = 0; exp_ack = 0; exp_lovf = 0; exp_rovf = 0;
      exp_addr = '0; exp_wdata = '0;
      return;
    end
    rd_wanted = bus.rd_req && !m_last_was_read;
    l_can     = (lq.size() > 0) && !bus.flush;
    r_can     = (rq.size() > 0) && !bus.flush;
    l_urgent  = l_can && (lq.size() >= AF);
    r_urgent  = r_can && (rq.size() >= AF);
    // 0 none, 1 read, 2 left write, 3 right write
    if (l_urgent && r_urgent)      choice = m_prefer_right ? 3 : 2;
    else if (l_urgent)             choice = 2;
    else if (r_urgent)             choice = 3;
    else if (rd_wanted)            choice = 1;
    else if (l_can && r_can)       choice = m_prefer_right ? 3 : 2;
    else if (l_can)                choice = 2;
    else if (r_can)                choice = 3;
    else                           choice = 0;

    exp_we  = (choice >= 2);
    exp_re  = (choice == 1);
    exp_ack = (choice == 1);
    m_last_was_read = (choice == 1);
    if (choice == 1) begin
      exp_addr = bus.rd_addr;
    end else if (choice == 2) begin
      item = lq.pop_front();
      exp_addr  = {1'b0, item[22:8]};
      exp_wdata = item[7:0];
      m_prefer_right = 1;
    end else if (choice == 3) begin
      item = rq.pop_front();
      exp_addr  = {1'b1, item[22:8]};
      exp_wdata = item[7:0];
      m_prefer_right = 0;
    end

    l_lost = 0;
    r_lost = 0;
    if (bus.flush) begin
      lq.delete();
      rq.delete();
    end else begin
      if (bus.l_vld) begin
        if (lq.size() < DEPTH) lq.push_back({bus.l_addr, bus.l_grey});
        else l_lost = 1;
      end
      if (bus.r_vld) begin
        if (rq.size() < DEPTH) rq.push_back({bus.r_addr, bus.r_grey});
        else r_lost = 1;
      end
    end
    if (bus.clr_ovf) begin
      exp_lovf = 0;
      exp_rovf = 0;
    end
    if (l_lost) exp_lovf = 1;
    if (r_lost) exp_rovf = 1;
  endtask

  // Model update on every rising edge, comparison shortly after.
  always begin
    @(posedge pclk);
    modelStep();
    #2;
    checkOutput("ram_we",    bus.ram_we,    exp_we);
    checkOutput("ram_re",    bus.ram_re,    exp_re);
    checkOutput("rd_ack",    bus.rd_ack,    exp_ack);
    checkOutput("ram_addr",  bus.ram_addr,  exp_addr);
    checkOutput("ram_wdata", bus.ram_wdata, exp_wdata);
    checkOutput("l_ovf",     bus.l_ovf,     exp_lovf);
    checkOutput("r_ovf",     bus.r_ovf,     exp_rovf);
    checkOutput("busy",      bus.busy,
                (!rst && (lq.size() != 0 || rq.size() != 0 || bus.rd_req)) ? 1'b1 : 1'b0);
  end

  task automatic setInputs(input logic lv, input logic [14:0] la, input logic [7:0] lg,
                           input logic rv, input logic [14:0] ra, input logic [7:0] rg,
                           input logic fl, input logic co);
    bus.l_vld = lv; bus.l_addr = la; bus.l_grey = lg;
    bus.r_vld = rv; bus.r_addr = ra; bus.r_grey = rg;
    bus.flush = fl; bus.clr_ovf = co;
  endtask

  task automatic applyStimulus(input logic lv, input logic [14:0] la, input logic [7:0] lg,
                               input logic rv, input logic [14:0] ra, input logic [7:0] rg,
                               input logic fl, input logic co);
    @(negedge pclk);
    setInputs(lv, la, lg, rv, ra, rg, fl, co);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic resetDut();
    @(negedge pclk);
    rst = 1'b1;
    setInputs(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    bus.rd_req  = 1'b0;
    bus.rd_addr = '0;
    #1;
    checkOutput("rst_we",   bus.ram_we,   1'b0);
    checkOutput("rst_re",   bus.ram_re,   1'b0);
    checkOutput("rst_ack",  bus.rd_ack,   1'b0);
    checkOutput("rst_addr", bus.ram_addr, 16'h0000);
    checkOutput("rst_lovf", bus.l_ovf,    1'b0);
    checkOutput("rst_busy", bus.busy,     1'b0);
    @(negedge pclk);
    rst = 1'b0;
  endtask

  initial begin
    int dens_tab[4];
    int dens;
    setInputs(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    bus.rd_req  = 1'b0;
    bus.rd_addr = '0;
    rst = 1'b1;
    repeat (2) @(negedge pclk);

    // Single left pixel: write appears two cycles after the strobe cycle.
    resetDut();
    applyStimulus(1'b1, 15'd100, 8'h5A, 1'b0, '0, '0, 1'b0, 1'b0);
    idleCycle();
    checkOutput("single_we_early", bus.ram_we, 1'b0);
    idleCycle();
    checkOutput("single_we",    bus.ram_we,    1'b1);
    checkOutput("single_addr",  bus.ram_addr,  16'h0064);
    checkOutput("single_wdata", bus.ram_wdata, 8'h5A);
    idleCycle();
    checkOutput("single_we_off",    bus.ram_we,   1'b0);
    checkOutput("single_addr_hold", bus.ram_addr, 16'h0064);

    // Simultaneous strobes: left first, right next.
    resetDut();
    applyStimulus(1'b1, 15'd5, 8'h11, 1'b1, 15'd7, 8'h22, 1'b0, 1'b0);
    idleCycle();
    idleCycle();
    checkOutput("both_first_we",    bus.ram_we,    1'b1);
    checkOutput("both_first_addr",  bus.ram_addr,  16'h0005);
    checkOutput("both_first_wdata", bus.ram_wdata, 8'h11);
    idleCycle();
    checkOutput("both_second_we",    bus.ram_we,    1'b1);
    checkOutput("both_second_addr",  bus.ram_addr,  16'h8007);
    checkOutput("both_second_wdata", bus.ram_wdata, 8'h22);
    idleCycle();
    checkOutput("both_done_we", bus.ram_we, 1'b0);

    // Continuous read request with back-to-back left strobes: almost-full preempts.
    resetDut();
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(1'b1, 15'(k), 8'(k), 1'b0, '0, '0, 1'b0, 1'b0);
      if (k == 1) begin
        bus.rd_req  = 1'b1;
        bus.rd_addr = 16'h8123;
      end
      if (k == 6) begin
        checkOutput("pre_read_re",   bus.ram_re,   1'b1);
        checkOutput("pre_read_addr", bus.ram_addr, 16'h8123);
      end
      if (k == 7) begin
        checkOutput("pre_w3_addr", bus.ram_addr, 16'h0003);
      end
    end
    idleCycle();
    checkOutput("preempt_we",    bus.ram_we,    1'b1);
    checkOutput("preempt_re",    bus.ram_re,    1'b0);
    checkOutput("preempt_addr",  bus.ram_addr,  16'h0004);
    checkOutput("preempt_wdata", bus.ram_wdata, 8'h04);
    bus.rd_req = 1'b0;
    repeat (10) idleCycle();

    // Both sides strobing every cycle: right overflows first, then left; set beats clear.
    resetDut();
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(1'b1, 15'(k), 8'(k), 1'b1, 15'(k + 100), 8'(k + 100), 1'b0, k == 9);
      if (k == 9) begin
        checkOutput("ovf8_r", bus.r_ovf, 1'b1);
        checkOutput("ovf8_l", bus.l_ovf, 1'b0);
      end
    end
    idleCycle();
    checkOutput("ovf9_l_setwins", bus.l_ovf, 1'b1);
    checkOutput("ovf9_r_cleared", bus.r_ovf, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    idleCycle();
    checkOutput("ovf_clr_l", bus.l_ovf, 1'b0);
    repeat (12) idleCycle();

    // Flush with entries queued and a strobe in the flush cycle.
    resetDut();
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b1, 15'(k), 8'(k), 1'b1, 15'(k + 100), 8'(k + 100), 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 15'd77, 8'h77, 1'b1, 15'd78, 8'h78, 1'b1, 1'b0);
    checkOutput("flush_inflight_we",   bus.ram_we,   1'b1);
    checkOutput("flush_inflight_addr", bus.ram_addr, 16'h8065);
    idleCycle();
    checkOutput("flush_we",   bus.ram_we,   1'b0);
    checkOutput("flush_busy", bus.busy,     1'b0);
    checkOutput("flush_hold", bus.ram_addr, 16'h8065);
    idleCycle();
    checkOutput("flush_we2", bus.ram_we, 1'b0);

    // Asynchronous reset during a read grant.
    resetDut();
    @(negedge pclk);
    bus.rd_req  = 1'b1;
    bus.rd_addr = 16'h8ABC;
    @(posedge pclk);
    #3;
    checkOutput("arst_pre_re", bus.ram_re, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("arst_re",   bus.ram_re,   1'b0);
    checkOutput("arst_ack",  bus.rd_ack,   1'b0);
    checkOutput("arst_addr", bus.ram_addr, 16'h0000);
    checkOutput("arst_busy", bus.busy,     1'b0);
    @(negedge pclk);
    @(negedge pclk);
    rst = 1'b0;
    #1;
    checkOutput("arst_rel_re", bus.ram_re, 1'b0);
    @(negedge pclk);
    checkOutput("arst_regrant_re",   bus.ram_re,   1'b1);
    checkOutput("arst_regrant_ack",  bus.rd_ack,   1'b1);
    checkOutput("arst_regrant_addr", bus.ram_addr, 16'h8ABC);
    bus.rd_req = 1'b0;
    repeat (3) idleCycle();

    // Randomised traffic at varying strobe densities.
    dens_tab = '{4, 2, 3, 8};
    for (int c = 0; c < 4000; c++) begin
      dens = dens_tab[(c / 500) % 4];
      applyStimulus(($urandom % dens) == 0, 15'($urandom % FRAME_PIXELS), 8'($urandom),
                    ($urandom % dens) == 0, 15'($urandom % FRAME_PIXELS), 8'($urandom),
                    ($urandom % 97) == 0, ($urandom % 29) == 0);
      if (bus.rd_req && bus.rd_ack) begin
        if (($urandom % 4) != 0) bus.rd_req = 1'b0;
        else bus.rd_addr = 16'($urandom);
      end else if (!bus.rd_req && (($urandom % 3) == 0)) begin
        bus.rd_req  = 1'b1;
        bus.rd_addr = 16'($urandom);
      end
    end
    bus.rd_req = 1'b0;
    repeat (30) idleCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
